// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: default sizes and the
// controller state encoding.
package div_iter_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = 6;

   typedef enum logic [1:0] {
      DIV_IDLE    = 2'd0,
      DIV_DIVZERO = 2'd1,
      DIV_ON      = 2'd2,
      DIV_END     = 2'd3
   } divState_t;

endpackage

// File: rtl/div_iter_if.sv
// EX-stage divider port bundle. The master side is the pipeline (start,
// operands, annul); the slave side is the divider (result, done, stall).
interface div_iter_if
   import div_iter_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
);

   logic                 start_i;
   logic                 signed_i;
   logic                 annul_i;
   logic [WIDTH-1:0]     opdata1_i;
   logic [WIDTH-1:0]     opdata2_i;
   logic [2*WIDTH-1:0]   result_o;
   logic                 ready_o;
   logic                 div_running;

   modport master (
      output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
      input  result_o, ready_o, div_running
   );

   modport slave (
      input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
      output result_o, ready_o, div_running
   );

endinterface

// File: rtl/div_iter_step.sv
// One radix-2 restoring division step. The kept remainder is shifted left
// with the next dividend bit; the divisor is subtracted and the difference
// is kept only when it does not borrow.
module div_step
   import div_iter_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   remIn,
   input  logic             dvdBit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   remOut,
   output logic             qBit
);

   logic [WIDTH+1:0] shifted_s;
   logic [WIDTH+1:0] diff_s;

   // Trial subtraction; the top bit of the difference is the borrow.
   always_comb begin
      shifted_s = {remIn, dvdBit};
      diff_s    = shifted_s - {2'b00, divisor};
      if (diff_s[WIDTH+1] == 1'b0) begin
         remOut = diff_s[WIDTH:0];
         qBit   = 1'b1;
      end else begin
         remOut = shifted_s[WIDTH:0];
         qBit   = 1'b0;
      end
   end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider for DIV/DIVU in EX. Operands are reduced to
// magnitudes on entry, WIDTH restoring steps produce the unsigned quotient
// and remainder, and signs are re-applied on the way into the result register.
module div_iter
   import div_iter_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = DIV_CNT_W
) (
   input logic      clk,
   input logic      rst,
   div_iter_if.slave bus
);

   divState_t            state_r;
   divState_t            nextState_s;
   logic [CNT_W-1:0]     count_r;
   logic [WIDTH:0]       partRem_r;
   logic [WIDTH:0]       remNext_s;
   logic [WIDTH-1:0]     dvdQuo_r;
   logic [WIDTH-1:0]     divisor_r;
   logic                 signed_r;
   logic                 sign1_r;
   logic                 sign2_r;
   logic [2*WIDTH-1:0]   result_r;
   logic                 ready_r;
   logic                 qBit_s;
   logic                 goStart_s;
   logic                 abort_s;
   logic                 lastStep_s;
   logic                 divZero_s;
   logic [WIDTH-1:0]     quotRaw_s;
   logic [WIDTH-1:0]     remRaw_s;
   logic [WIDTH-1:0]     quotFinal_s;
   logic [WIDTH-1:0]     remFinal_s;

   // Two's-complement magnitude of an operand when it is negative.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic neg);
      if (neg) begin
         return -v;
      end else begin
         return v;
      end
   endfunction

   div_step #(.WIDTH(WIDTH)) uStep (
      .remIn   (partRem_r),
      .dvdBit  (dvdQuo_r[WIDTH-1]),
      .divisor (divisor_r),
      .remOut  (remNext_s),
      .qBit    (qBit_s)
   );

   // Handshake decode: a new divide, an abort (annul or illegal start drop)
   // and the final iteration.
   always_comb begin
      goStart_s  = bus.start_i & ~bus.annul_i;
      abort_s    = bus.annul_i | ~bus.start_i;
      lastStep_s = (count_r == CNT_W'(WIDTH-1));
      divZero_s  = (bus.opdata2_i == {WIDTH{1'b0}});
   end

   // Final sign fix-up applied to the outcome of the last restoring step.
   always_comb begin
      quotRaw_s = {dvdQuo_r[WIDTH-2:0], qBit_s};
      remRaw_s  = remNext_s[WIDTH-1:0];
      if (signed_r && (sign1_r ^ sign2_r)) begin
         quotFinal_s = -quotRaw_s;
      end else begin
         quotFinal_s = quotRaw_s;
      end
      if (signed_r && sign1_r) begin
         remFinal_s = -remRaw_s;
      end else begin
         remFinal_s = remRaw_s;
      end
   end

   // Controller next-state logic; annul has priority over everything.
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         DIV_IDLE: begin
            if (goStart_s) begin
               if (divZero_s) begin
                  nextState_s = DIV_DIVZERO;
               end else begin
                  nextState_s = DIV_ON;
               end
            end else begin
               nextState_s = DIV_IDLE;
            end
         end
         DIV_DIVZERO: begin
            if (abort_s) begin
               nextState_s = DIV_IDLE;
            end else begin
               nextState_s = DIV_END;
            end
         end
         DIV_ON: begin
            if (abort_s) begin
               nextState_s = DIV_IDLE;
            end else if (lastStep_s) begin
               nextState_s = DIV_END;
            end else begin
               nextState_s = DIV_ON;
            end
         end
         DIV_END: begin
            nextState_s = DIV_IDLE;
         end
         default: begin
            nextState_s = DIV_IDLE;
         end
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= DIV_IDLE;
      end else begin
         state_r <= nextState_s;
      end
   end

   // Operand capture in IDLE and one shift/subtract iteration per ON cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r   <= {CNT_W{1'b0}};
         partRem_r <= {(WIDTH+1){1'b0}};
         dvdQuo_r  <= {WIDTH{1'b0}};
         divisor_r <= {WIDTH{1'b0}};
         signed_r  <= 1'b0;
         sign1_r   <= 1'b0;
         sign2_r   <= 1'b0;
      end else begin
         case (state_r)
            DIV_IDLE: begin
               if (nextState_s == DIV_ON) begin
                  count_r   <= {CNT_W{1'b0}};
                  partRem_r <= {(WIDTH+1){1'b0}};
                  dvdQuo_r  <= magnitude(bus.opdata1_i,
                                         bus.signed_i & bus.opdata1_i[WIDTH-1]);
                  divisor_r <= magnitude(bus.opdata2_i,
                                         bus.signed_i & bus.opdata2_i[WIDTH-1]);
                  signed_r  <= bus.signed_i;
                  sign1_r   <= bus.opdata1_i[WIDTH-1];
                  sign2_r   <= bus.opdata2_i[WIDTH-1];
               end
            end
            DIV_ON: begin
               partRem_r <= remNext_s;
               dvdQuo_r  <= {dvdQuo_r[WIDTH-2:0], qBit_s};
               count_r   <= count_r + CNT_W'(1);
            end
            default: begin
               count_r <= count_r;
            end
         endcase
      end
   end

   // Done pulse and result register; the result only changes on entry to END.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_r  <= 1'b0;
         result_r <= {(2*WIDTH){1'b0}};
      end else begin
         ready_r <= (nextState_s == DIV_END);
         if (nextState_s == DIV_END) begin
            if (state_r == DIV_DIVZERO) begin
               result_r <= {(2*WIDTH){1'b0}};
            end else begin
               result_r <= {remFinal_s, quotFinal_s};
            end
         end else begin
            result_r <= result_r;
         end
      end
   end

   assign bus.result_o    = result_r;
   assign bus.ready_o     = ready_r;
   assign bus.div_running = bus.start_i & ~bus.annul_i & ~ready_r;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: a cycle-level behavioural model built from
// plain integer division and a countdown, compared against the DUT every cycle.
module tb_div_iter;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   nChecks = 0;
   int   nErrors = 0;
   bit   chkEn = 1'b0;

   div_iter_if ifc ();

   div_iter dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference result {remainder, quotient}; signed division truncates toward zero.
   function automatic logic [63:0] refDiv(input bit sgn, input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] qv, rv;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      qv = q;
      rv = r;
      return {rv[31:0], qv[31:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         if (nErrors <= 30) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural model: idle / busy countdown / done, plus the held result.
   bit          mBusy = 1'b0;
   bit          mReady = 1'b0;
   int          mLeft = 0;
   logic [63:0] mPend = 64'd0;
   logic [63:0] mRes = 64'd0;

   always @(posedge clk) begin
      if (rst) begin
         mBusy  <= 1'b0;
         mReady <= 1'b0;
         mRes   <= 64'd0;
         mLeft  <= 0;
      end else if (mReady) begin
         mReady <= 1'b0;
         mBusy  <= 1'b0;
      end else if (mBusy) begin
         if (ifc.annul_i || !ifc.start_i) begin
            mBusy <= 1'b0;
         end else if (mLeft == 1) begin
            mBusy  <= 1'b0;
            mReady <= 1'b1;
            mRes   <= mPend;
         end else begin
            mLeft <= mLeft - 1;
         end
      end else if (ifc.start_i && !ifc.annul_i) begin
         mBusy <= 1'b1;
         mLeft <= (ifc.opdata2_i == 32'd0) ? 1 : W;
         mPend <= refDiv(ifc.signed_i, ifc.opdata1_i, ifc.opdata2_i);
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chkEn) begin
         check("ready_o", {63'd0, ifc.ready_o}, {63'd0, mReady});
         check("div_running", {63'd0, ifc.div_running},
               {63'd0, ifc.start_i & ~ifc.annul_i & ~mReady});
         check("result_o", ifc.result_o, mRes);
      end
   end

   // Runs one divide from the current cycle (caller is at posedge+2).
   task automatic runDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input int annulAt, input bit keepStart,
                         output int latency, output logic [63:0] res);
      int  startCyc;
      bit  done;
      ifc.start_i   = 1'b1;
      ifc.signed_i  = sgn;
      ifc.opdata1_i = a;
      ifc.opdata2_i = b;
      ifc.annul_i   = 1'b0;
      startCyc = cyc;
      latency  = -1;
      res      = 64'd0;
      done     = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         if (ifc.ready_o) begin
            latency = cyc - startCyc;
            res     = ifc.result_o;
            done    = 1'b1;
         end else if (annulAt > 0 && k == annulAt) begin
            done = 1'b1;
         end
         @(posedge clk); #2;
         if (!done) begin
            ifc.opdata1_i = $urandom;
            ifc.opdata2_i = $urandom;
            ifc.signed_i  = $urandom_range(0, 1);
            ifc.annul_i   = (k + 1 == annulAt);
         end
      end
      check("op_done", {63'd0, done}, 64'd1);
      ifc.annul_i = 1'b0;
      if (!keepStart) ifc.start_i = 1'b0;
   endtask

   function automatic logic [31:0] pickOp(input int sel);
      case (sel)
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(1, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int          lat, lat2, r1, r2;
      logic [63:0] res;
      ifc.start_i   = 1'b0;
      ifc.signed_i  = 1'b0;
      ifc.annul_i   = 1'b0;
      ifc.opdata1_i = 32'd0;
      ifc.opdata2_i = 32'd0;

      // Pin the reference model with hand-computed values.
      check("ref_100_7", refDiv(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
      check("ref_m7_2", refDiv(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      check("ref_ovf", refDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'd0, 32'h8000_0000});
      check("ref_divu_big", refDiv(1'b0, 32'h8000_0000, 32'hFFFF_FFFF), {32'h8000_0000, 32'd0});

      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      chkEn = 1'b1;
      @(negedge clk);
      check("reset_ready", {63'd0, ifc.ready_o}, 64'd0);
      check("reset_result", ifc.result_o, 64'd0);
      check("reset_running", {63'd0, ifc.div_running}, 64'd0);
      @(posedge clk); #2;

      // 1) DIVU 100/7
      runDiv(1'b0, 32'd100, 32'd7, -1, 1'b0, lat, res);
      check("divu_latency", 64'(lat), 64'd33);
      check("divu_result", res, {32'd2, 32'd14});
      // 2) DIV -7/2
      runDiv(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, lat, res);
      check("div_neg_result", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      // 3) divide by zero, big unsigned
      runDiv(1'b1, 32'd5, 32'd0, -1, 1'b0, lat, res);
      check("divzero_latency", 64'(lat), 64'd2);
      check("divzero_result", res, 64'd0);
      runDiv(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, lat, res);
      check("divu_big_result", res, {32'h8000_0000, 32'd0});
      // 4) signed overflow
      runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, lat, res);
      check("div_ovf_result", res, {32'd0, 32'h8000_0000});
      // 5) annul at cycle 10, then DIVU 9/3
      runDiv(1'b0, 32'd1000, 32'd3, 10, 1'b0, lat, res);
      check("annul_no_ready", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
      runDiv(1'b0, 32'd9, 32'd3, -1, 1'b0, lat, res);
      check("after_annul_result", res, {32'd0, 32'd3});
      // annul wins over start in the same cycle
      ifc.start_i = 1'b1; ifc.annul_i = 1'b1; ifc.opdata2_i = 32'd5;
      @(posedge clk); #2;
      ifc.start_i = 1'b0; ifc.annul_i = 1'b0;
      repeat (3) @(posedge clk); #2;
      // 6) reset mid-divide
      ifc.start_i = 1'b1; ifc.signed_i = 1'b0;
      ifc.opdata1_i = 32'd12345; ifc.opdata2_i = 32'd7;
      repeat (5) @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0; ifc.start_i = 1'b0;
      @(negedge clk);
      check("midrst_ready", {63'd0, ifc.ready_o}, 64'd0);
      check("midrst_result", ifc.result_o, 64'd0);
      @(posedge clk); #2;
      // back-to-back DIVU pair
      runDiv(1'b0, 32'd77, 32'd5, -1, 1'b1, lat, res);
      r1 = cyc - 1;
      runDiv(1'b0, 32'd1234567, 32'd89, -1, 1'b0, lat2, res);
      r2 = cyc - 1;
      check("b2b_gap", 64'(r2 - r1), 64'd34);
      check("b2b_result", res, {32'd1234567 % 32'd89, 32'd1234567 / 32'd89});

      // Randomized divides with occasional annul, gaps and back-to-back starts.
      for (int n = 0; n < 40; n++) begin
         bit kp;
         int an;
         kp = ($urandom_range(0, 3) == 0);
         an = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 34)) : -1;
         runDiv(1'($urandom_range(0, 1)), pickOp($urandom_range(0, 9)),
                pickOp($urandom_range(0, 9)), an, kp, lat, res);
         if (!kp) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #2;
         end
      end
      ifc.start_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
